// File: rtl/ulpi_reg_arbiter.sv
// Round-robin arbiter funnelling two register-write clients into one ULPI write engine.
// Launch is registered (one edge after REQ); ACK pulses one cycle after engine BUSY falls or on timeout.
module ulpi_reg_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       REQ0,
  input  logic       REQ1,
  input  logic [5:0] ADDR0,
  input  logic [5:0] ADDR1,
  input  logic [7:0] DATA0,
  input  logic [7:0] DATA1,
  output logic       ACK0,
  output logic       ACK1,
  output logic       ERR,
  output logic [1:0] GNT,
  output logic       BUSY,
  input  logic       DIR,
  output logic       WR_START,
  output logic [5:0] WR_ADDR,
  output logic [7:0] WR_DATA,
  input  logic       WR_BUSY,
  output logic       ENG_RST
);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE, DONE} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state_q;
  logic        last_q;
  logic [15:0] cnt_q;
  logic        ack0_q, ack1_q, err_q, eng_rst_q, wr_start_q;
  logic [1:0]  gnt_q;
  logic [5:0]  wr_addr_q;
  logic [7:0]  wr_data_q;

  logic        launch_d;
  logic        win1_d;
  logic [15:0] cnt_d;
  logic        tmo_d;

  // On a tie the client that did not win last time takes the grant.
  always_comb begin
    launch_d = (REQ0 | REQ1) & ~DIR & ~WR_BUSY;
    win1_d   = REQ1 & (~REQ0 | ~last_q);
    cnt_d    = cnt_q + 16'd1;
    tmo_d    = (cnt_d == TMO);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      eng_rst_q  <= 1'b0;
      wr_start_q <= 1'b0;
      gnt_q      <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
      err_q      <= 1'b0;
      eng_rst_q  <= 1'b0;
      wr_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (launch_d) begin
            state_q    <= WAIT_BUSY;
            gnt_q      <= {win1_d, ~win1_d};
            last_q     <= win1_d;
            wr_addr_q  <= win1_d ? ADDR1 : ADDR0;
            wr_data_q  <= win1_d ? DATA1 : DATA0;
            wr_start_q <= 1'b1;
            cnt_q      <= '0;
          end
        end
        WAIT_BUSY, WAIT_DONE: begin
          cnt_q <= cnt_d;
          // A timeout coinciding with BUSY falling is still reported as an error.
          if (tmo_d) begin
            state_q   <= DONE;
            ack0_q    <= gnt_q[0];
            ack1_q    <= gnt_q[1];
            err_q     <= 1'b1;
            eng_rst_q <= 1'b1;
          end else if (state_q == WAIT_BUSY) begin
            if (WR_BUSY) state_q <= WAIT_DONE;
          end else if (!WR_BUSY) begin
            state_q <= DONE;
            ack0_q  <= gnt_q[0];
            ack1_q  <= gnt_q[1];
          end
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign ACK0     = ack0_q;
  assign ACK1     = ack1_q;
  assign ERR      = err_q;
  assign ENG_RST  = eng_rst_q;
  assign GNT      = gnt_q;
  assign BUSY     = (state_q != IDLE);
  assign WR_START = wr_start_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;

endmodule

// File: tb/tb_ulpi_reg_arbiter.sv
// Bench for ulpi_reg_arbiter: directed scenarios plus randomized two-client traffic against a rule-level scoreboard.
module tb_ulpi_reg_arbiter;

  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, dir, wr_busy;
  logic [5:0] addr0, addr1, wr_addr;
  logic [7:0] data0, data1, wr_data;
  logic       ack0, ack1, err, busy, wr_start, eng_rst;
  logic [1:0] gnt;

  ulpi_reg_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .REQ0(req0), .REQ1(req1), .ADDR0(addr0), .ADDR1(addr1), .DATA0(data0), .DATA1(data1),
    .ACK0(ack0), .ACK1(ack1), .ERR(err), .GNT(gnt), .BUSY(busy), .DIR(dir),
    .WR_START(wr_start), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_BUSY(wr_busy), .ENG_RST(eng_rst)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int len_mode = 3;   // engine BUSY length per transaction: 0 = hang, 255 = random
  int eng_len = 3;
  bit rdone = 0;

  typedef struct { int who; int dly; bit err; int lc; } exp_t;
  exp_t        expq[$];
  logic [13:0] cq0[$], cq1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Scoreboard monitor: inputs captured at one negedge are what the DUT samples at the next posedge.
  initial begin
    logic p_req0, p_req1, p_dir, p_busy, last_m;
    int w, L;
    exp_t e;
    logic [13:0] ent;
    p_req0 = 0; p_req1 = 0; p_dir = 0; p_busy = 0; last_m = 1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        last_m = 1;
        expq.delete(); cq0.delete(); cq1.delete();
      end else begin
        chk("busy_vs_gnt", {31'd0, busy}, {31'd0, |gnt});
        chk("gnt_onehot0", {31'd0, $onehot0(gnt)}, 32'd1);
        chk("err_outside_ack", {31'd0, (err | eng_rst) & ~(ack0 | ack1)}, 32'd0);
        if (wr_start) begin
          w = (p_req1 && (!p_req0 || !last_m)) ? 1 : 0;
          chk("launch_gnt", {30'd0, gnt}, (w == 1) ? 32'd2 : 32'd1);
          chk("launch_dir", {31'd0, p_dir}, 32'd0);
          chk("launch_wrbusy", {31'd0, p_busy}, 32'd0);
          chk("launch_req", {31'd0, (w == 1) ? p_req1 : p_req0}, 32'd1);
          chk("launch_overlap", expq.size(), 32'd0);
          if ((w == 1) ? (cq1.size() == 0) : (cq0.size() == 0)) fail("launch_no_request");
          else chk("launch_addr_data", {18'd0, wr_addr, wr_data}, {18'd0, (w == 1) ? cq1[0] : cq0[0]});
          last_m = (w == 1);
          L = (len_mode == 255) ? int'($urandom_range(0, 6)) : len_mode;
          eng_len = L;
          e.who = w;
          e.err = (L == 0) || (L + 2 >= TMO);
          e.dly = e.err ? TMO : L + 2;
          e.lc  = cyc;
          expq.push_back(e);
        end
        if (ack0 | ack1) begin
          if (expq.size() == 0) fail("ack_unexpected");
          else begin
            e = expq.pop_front();
            chk("ack_who", {30'd0, ack1, ack0}, (e.who == 1) ? 32'd2 : 32'd1);
            chk("ack_gnt", {30'd0, gnt}, (e.who == 1) ? 32'd2 : 32'd1);
            chk("ack_err", {31'd0, err}, {31'd0, e.err});
            chk("ack_eng_rst", {31'd0, eng_rst}, {31'd0, e.err});
            chk("ack_latency", cyc - e.lc, e.dly);
            if (e.who == 1 && cq1.size() != 0) ent = cq1.pop_front();
            if (e.who == 0 && cq0.size() != 0) ent = cq0.pop_front();
          end
        end
      end
      p_req0 = req0; p_req1 = req1; p_dir = dir; p_busy = wr_busy;
    end
  end

  // Engine model: samples WRITE_DATA at an edge, raises BUSY just after it and holds it eng_len cycles.
  initial begin
    logic st, er;
    int rem;
    bit hang;
    wr_busy = 0; rem = 0; hang = 0;
    forever begin
      @(negedge clk);
      st = wr_start; er = eng_rst;
      @(posedge clk); #1;
      if (rst || er) begin
        wr_busy = 0; hang = 0;
      end else if (wr_busy) begin
        if (!hang) begin
          if (rem <= 1) wr_busy = 0;
          else rem--;
        end
      end else if (st) begin
        wr_busy = 1; rem = eng_len; hang = (eng_len == 0);
      end
    end
  end

  task automatic push_req(input int i, input logic [5:0] a, input logic [7:0] d);
    if (i == 0) begin addr0 = a; data0 = d; cq0.push_back({a, d}); req0 = 1; end
    else        begin addr1 = a; data1 = d; cq1.push_back({a, d}); req1 = 1; end
  endtask

  task automatic drop_req(input int i);
    if (i == 0) req0 = 0;
    else if (i == 1) req1 = 0;
  endtask

  task automatic wait_ack(output int who, output int k);
    who = -1; k = 0;
    while (who < 0 && k < 100) begin
      @(posedge clk); #1;
      k++;
      if (ack0 | ack1) who = ack1 ? 1 : 0;
    end
    if (who < 0) fail("ack_timeout");
  endtask

  task automatic serve(input int who_exp, input string name, output int k);
    int who;
    wait_ack(who, k);
    chk({name, "_who"}, who, who_exp);
    @(posedge clk); #1;
    drop_req(who);
  endtask

  task automatic client_loop(input int i, input int n);
    bit got;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
      push_req(i, 6'($urandom), 8'($urandom));
      got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(posedge clk); #1;
        if ((i == 0) ? ack0 : ack1) got = 1;
      end
      if (!got) fail("rand_ack_timeout");
      drop_req(i);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, who;
    int bad;
    rst = 1; req0 = 0; req1 = 0; dir = 0;
    addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {16'd0, ack0, ack1, err, gnt, busy, wr_start, wr_addr, wr_data, eng_rst}, 32'd0);
    rst = 0;
    @(posedge clk); #1;

    // simultaneous requests from reset: client 0 then client 1
    len_mode = 3;
    push_req(0, 6'h11, 8'hA1);
    push_req(1, 6'h22, 8'hB2);
    @(posedge clk); #1;
    chk("sim_first_gnt", {30'd0, gnt}, 32'd1);
    chk("sim_first_addr", {26'd0, wr_addr}, 32'h11);
    serve(0, "sim1", k);
    @(posedge clk); #1;
    chk("sim_second_gnt", {30'd0, gnt}, 32'd2);
    chk("sim_second_addr", {26'd0, wr_addr}, 32'h22);
    chk("sim_second_data", {24'd0, wr_data}, 32'hB2);
    serve(1, "sim2", k);

    // single write with a 3-cycle engine
    push_req(0, 6'h04, 8'h48);
    @(posedge clk); #1;
    chk("single_start", {31'd0, wr_start}, 32'd1);
    chk("single_gnt", {30'd0, gnt}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_addr_data", {18'd0, wr_addr, wr_data}, 32'h0448);
    @(posedge clk); #1;
    chk("single_start_drop", {31'd0, wr_start}, 32'd0);
    wait_ack(who, k);
    chk("single_who", who, 0);
    chk("single_latency", k + 1, 5);
    chk("single_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    drop_req(who);

    // tie after client 0 was served: client 1 wins
    push_req(0, 6'h33, 8'hC3);
    push_req(1, 6'h2A, 8'hD4);
    serve(1, "tie1", k);
    serve(0, "tie2", k);

    // DIR holds off launches
    dir = 1;
    push_req(1, 6'h3F, 8'hFF);
    bad = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (wr_start | busy) bad++;
    end
    chk("dir_holdoff", bad, 0);
    dir = 0;
    @(posedge clk); #1;
    chk("dir_release_start", {31'd0, wr_start}, 32'd1);
    chk("dir_release_gnt", {30'd0, gnt}, 32'd2);
    serve(1, "dir", k);

    // hung engine: timeout after TMO wait cycles
    len_mode = 0;
    push_req(0, 6'h05, 8'h55);
    wait_ack(who, k);
    chk("tmo_who", who, 0);
    chk("tmo_latency", k - 1, TMO);
    chk("tmo_err", {31'd0, err}, 32'd1);
    chk("tmo_eng_rst", {31'd0, eng_rst}, 32'd1);
    @(posedge clk); #1;
    chk("tmo_after", {27'd0, ack0, err, eng_rst, busy, gnt != 2'b00}, 32'd0);
    drop_req(who);

    // timeout boundary: BUSY falling on the timeout edge is still an error, one cycle earlier is not
    len_mode = 6;
    push_req(1, 6'h06, 8'h66);
    wait_ack(who, k);
    chk("bound6_latency", k - 1, 8);
    chk("bound6_err", {31'd0, err}, 32'd1);
    @(posedge clk); #1;
    drop_req(who);
    len_mode = 5;
    push_req(0, 6'h07, 8'h77);
    wait_ack(who, k);
    chk("bound5_latency", k - 1, 7);
    chk("bound5_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    drop_req(who);

    // reset during WAIT_DONE drops the transaction; LAST returns to 1
    len_mode = 3;
    push_req(0, 6'h0A, 8'h0B);
    repeat (3) @(posedge clk);
    #1;
    chk("midop_busy", {31'd0, busy}, 32'd1);
    #2 rst = 1;
    #1;
    chk("midop_reset_outs", {16'd0, ack0, ack1, err, gnt, busy, wr_start, wr_addr, wr_data, eng_rst}, 32'd0);
    @(posedge clk); #1;
    push_req(0, 6'h0A, 8'h0B);
    push_req(1, 6'h1C, 8'h2D);
    rst = 0;
    serve(0, "post_rst1", k);
    serve(1, "post_rst2", k);

    // randomized traffic from both clients with DIR noise and random engine timing
    len_mode = 255;
    fork
      begin
        fork
          client_loop(0, 40);
          client_loop(1, 40);
        join
        rdone = 1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          dir = ($urandom_range(0, 5) == 0);
        end
        dir = 0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("final_pending", expq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
